// File: rtl/pmp_csr_sequencer_pkg.sv
// Shared definitions for the PMP CSR sequencer: FSM states, pmpcfg A-field
// encodings and CSR base numbers.
// Optional feature macro: PMP_GRAIN_EN (G-granularity read view and NA4 rewrite).
package pmp_csr_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    FLUSH = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] A_OFF   = 2'b00;
  localparam logic [1:0] A_TOR   = 2'b01;
  localparam logic [1:0] A_NA4   = 2'b10;
  localparam logic [1:0] A_NAPOT = 2'b11;

  localparam logic [11:0] PMPCFG0  = 12'h3A0;
  localparam logic [11:0] PMPADDR0 = 12'h3B0;

`ifdef PMP_GRAIN_EN
  localparam bit GRAIN_EN = 1'b1;
`else
  localparam bit GRAIN_EN = 1'b0;
`endif

endpackage

// File: rtl/pmp_cfg_filter.sv
// Per-byte pmpcfg write filter: keeps locked bytes and reserved W=1,R=0
// writes unchanged, otherwise stores the new byte with bits 6:5 cleared.
// With PMP_GRAIN_EN and G>=1, an NA4 selection is stored as OFF.
module pmp_cfg_filter
  import pmp_csr_sequencer_pkg::*;
#(
  parameter int G = 2
) (
  input  logic [7:0] i_old,
  input  logic [7:0] i_new,
  output logic [7:0] o_byte
);

  // Lock and WARL legalisation of one configuration byte
  always_comb begin
    o_byte = i_new & 8'h9F;
    if (GRAIN_EN && (G >= 1) && (i_new[4:3] == A_NA4)) begin
      o_byte[4:3] = A_OFF;
    end
    if (i_old[7] || (i_new[1] && !i_new[0])) begin
      o_byte = i_old;
    end
  end

endmodule

// File: rtl/pmp_csr_sequencer.sv
// PMP configuration owner: serialises pmpcfg/pmpaddr CSR accesses through an
// IDLE/APPLY/FLUSH/RESP sequence, applies lock and WARL rules, and holds the
// response until a downstream flush is acknowledged after any real change.
// Optional feature macro: PMP_GRAIN_EN (see pmp_csr_sequencer_pkg).
module pmp_csr_sequencer #(
  parameter int PMP_ENTRIES = 16,
  parameter int PA_BITS     = 56,
  parameter int XLEN        = 64,
  parameter int G           = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 CSRReq,
  output logic                 CSRReady,
  input  logic                 CSRWrite,
  input  logic [11:0]          CSRAdr,
  input  logic [XLEN-1:0]      CSRWriteVal,
  output logic                 CSRRespValid,
  output logic [XLEN-1:0]      CSRReadVal,
  output logic                 CSRIllegal,
  output logic                 PMPFlushReq,
  input  logic                 PMPFlushAck,
  output logic [7:0]           PMPCFG_ARRAY_REGW  [PMP_ENTRIES],
  output logic [PA_BITS-3:0]   PMPADDR_ARRAY_REGW [PMP_ENTRIES]
);
  import pmp_csr_sequencer_pkg::*;

  localparam int NB = XLEN / 8;
  localparam int AW = PA_BITS - 2;

  state_t            r_state;
  logic              r_ready;
  logic              r_resp_valid;
  logic              r_illegal;
  logic              r_flush_req;
  logic [XLEN-1:0]   r_read_val;
  logic              r_write;
  logic [11:0]       r_adr;
  logic [XLEN-1:0]   r_wval;
  logic [7:0]        r_cfg  [PMP_ENTRIES];
  logic [AW-1:0]     r_addr [PMP_ENTRIES];

  logic              w_is_cfg;
  logic              w_is_addr;
  logic              w_illegal;
  int                w_cfg_base;
  int                w_addr_off;
  logic [7:0]        w_cfg_old [NB];
  logic [7:0]        w_cfg_flt [NB];
  logic              w_cfg_changed;
  logic              w_addr_hit;
  logic              w_addr_locked;
  logic              w_addr_a1;
  logic [AW-1:0]     w_addr_old;
  logic [AW-1:0]     w_addr_view;
  logic [AW-1:0]     w_wval_addr;
  logic [XLEN-1:0]   w_read_val;
  logic              w_changed;

  // Decode the latched CSR number and gather the old state it names
  always_comb begin
    w_is_cfg      = (r_adr[11:4] == PMPCFG0[11:4]);
    w_is_addr     = (r_adr >= PMPADDR0) && (r_adr <= (PMPADDR0 + 12'd63));
    w_illegal     = !(w_is_cfg || w_is_addr) || (w_is_cfg && (XLEN == 64) && r_adr[0]);
    w_cfg_base    = (XLEN == 64) ? int'(r_adr[3:1]) * 8 : int'(r_adr[3:0]) * 4;
    w_addr_off    = int'(r_adr) - int'(PMPADDR0);
    w_wval_addr   = AW'(r_wval);
    w_cfg_changed = 1'b0;
    w_addr_hit    = 1'b0;
    w_addr_locked = 1'b0;
    w_addr_a1     = 1'b0;
    w_addr_old    = '0;
    w_read_val    = '0;

    for (int b = 0; b < NB; b++) begin
      w_cfg_old[b] = '0;
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        if (i == w_cfg_base + b) begin
          w_cfg_old[b] = r_cfg[i];
          if (w_cfg_flt[b] != r_cfg[i]) w_cfg_changed = 1'b1;
        end
      end
    end

    for (int i = 0; i < PMP_ENTRIES; i++) begin
      if (i == w_addr_off) begin
        w_addr_hit    = 1'b1;
        w_addr_old    = r_addr[i];
        w_addr_a1     = r_cfg[i][4];
        if (r_cfg[i][7]) w_addr_locked = 1'b1;
      end
      if ((i == w_addr_off + 1) && r_cfg[i][7] && (r_cfg[i][4:3] == A_TOR)) begin
        w_addr_locked = 1'b1;
      end
    end

    // Reads see G-granular address low bits; storage stays unmasked
    w_addr_view = w_addr_old;
    if (GRAIN_EN) begin
      for (int j = 0; j < AW; j++) begin
        if (w_addr_a1 && (j < G - 1))       w_addr_view[j] = 1'b1;
        else if (!w_addr_a1 && (j < G))     w_addr_view[j] = 1'b0;
      end
    end

    if (w_is_cfg) begin
      for (int b = 0; b < NB; b++) w_read_val[8*b +: 8] = w_cfg_old[b];
    end else if (w_addr_hit) begin
      w_read_val = XLEN'(w_addr_view);
    end

    w_changed = r_write && !w_illegal &&
                (w_is_cfg ? w_cfg_changed
                          : (w_addr_hit && !w_addr_locked && (w_wval_addr != w_addr_old)));
  end

  for (genvar gb = 0; gb < NB; gb++) begin : g_flt
    pmp_cfg_filter #(.G(G)) u_flt (
      .i_old  (w_cfg_old[gb]),
      .i_new  (r_wval[8*gb +: 8]),
      .o_byte (w_cfg_flt[gb])
    );
  end

  // Request sequencing FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_illegal    <= 1'b0;
      r_flush_req  <= 1'b0;
      r_read_val   <= '0;
      r_write      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp_valid <= 1'b0;
          if (CSRReq) begin
            r_write <= CSRWrite;
            r_adr   <= CSRAdr;
            r_wval  <= CSRWriteVal;
            r_ready <= 1'b0;
            r_state <= APPLY;
          end
        end
        APPLY: begin
          r_read_val <= w_illegal ? '0 : w_read_val;
          r_illegal  <= w_illegal;
          if (w_changed) begin
            r_flush_req <= 1'b1;
            r_state     <= FLUSH;
          end else begin
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        FLUSH: begin
          if (PMPFlushAck) begin
            r_flush_req  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Commit the filtered write at the end of APPLY; reset clears all entries
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        r_cfg[i]  <= '0;
        r_addr[i] <= '0;
      end
    end else if ((r_state == APPLY) && r_write && !w_illegal) begin
      if (w_is_cfg) begin
        for (int i = 0; i < PMP_ENTRIES; i++) begin
          for (int b = 0; b < NB; b++) begin
            if (i == w_cfg_base + b) r_cfg[i] <= w_cfg_flt[b];
          end
        end
      end else if (!w_addr_locked) begin
        for (int i = 0; i < PMP_ENTRIES; i++) begin
          if (i == w_addr_off) r_addr[i] <= w_wval_addr;
        end
      end
    end
  end

  assign CSRReady           = r_ready;
  assign CSRRespValid       = r_resp_valid;
  assign CSRReadVal         = r_read_val;
  assign CSRIllegal         = r_illegal;
  assign PMPFlushReq        = r_flush_req;
  assign PMPCFG_ARRAY_REGW  = r_cfg;
  assign PMPADDR_ARRAY_REGW = r_addr;

endmodule

// File: tb/tb_pmp_csr_sequencer.sv
// Directed bench for pmp_csr_sequencer (16 entries, 56-bit PA, XLEN=64).
module tb_pmp_csr_sequencer;

  logic        clk;
  logic        reset;
  logic        CSRReq;
  logic        CSRReady;
  logic        CSRWrite;
  logic [11:0] CSRAdr;
  logic [63:0] CSRWriteVal;
  logic        CSRRespValid;
  logic [63:0] CSRReadVal;
  logic        CSRIllegal;
  logic        PMPFlushReq;
  logic        PMPFlushAck;
  logic [7:0]  cfg_w  [16];
  logic [53:0] addr_w [16];

  int n_checks = 0;
  int n_fail   = 0;

  pmp_csr_sequencer #(
    .PMP_ENTRIES(16), .PA_BITS(56), .XLEN(64), .G(2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .CSRReq             (CSRReq),
    .CSRReady           (CSRReady),
    .CSRWrite           (CSRWrite),
    .CSRAdr             (CSRAdr),
    .CSRWriteVal        (CSRWriteVal),
    .CSRRespValid       (CSRRespValid),
    .CSRReadVal         (CSRReadVal),
    .CSRIllegal         (CSRIllegal),
    .PMPFlushReq        (PMPFlushReq),
    .PMPFlushAck        (PMPFlushAck),
    .PMPCFG_ARRAY_REGW  (cfg_w),
    .PMPADDR_ARRAY_REGW (addr_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full CSR transaction; ack_wait = cycles the ack stays low in FLUSH
  task automatic xact(input string tag, input logic wr, input logic [11:0] adr,
                      input logic [63:0] wv, input logic exp_flush, input int ack_wait,
                      input logic [63:0] exp_rd, input logic exp_ill);
    @(negedge clk);
    check({tag, ":ready"}, 64'(CSRReady), 64'd1);
    CSRReq = 1'b1; CSRWrite = wr; CSRAdr = adr; CSRWriteVal = wv;
    @(posedge clk); #1;
    CSRReq = 1'b0;
    check({tag, ":busy"}, 64'(CSRReady), 64'd0);
    @(posedge clk); #1;
    check({tag, ":flushreq"}, 64'(PMPFlushReq), 64'(exp_flush));
    if (exp_flush) begin
      check({tag, ":early_resp"}, 64'(CSRRespValid), 64'd0);
      repeat (ack_wait) begin @(posedge clk); #1; end
      check({tag, ":flush_held"}, 64'(PMPFlushReq), 64'd1);
      PMPFlushAck = 1'b1;
      @(posedge clk); #1;
      PMPFlushAck = 1'b0;
      check({tag, ":flush_drop"}, 64'(PMPFlushReq), 64'd0);
    end
    check({tag, ":respvalid"}, 64'(CSRRespValid), 64'd1);
    check({tag, ":readval"}, CSRReadVal, exp_rd);
    check({tag, ":illegal"}, 64'(CSRIllegal), 64'(exp_ill));
    @(posedge clk); #1;
    check({tag, ":resp_1cyc"}, 64'(CSRRespValid), 64'd0);
  endtask

  initial begin
    reset = 1'b1; CSRReq = 1'b0; CSRWrite = 1'b0; CSRAdr = '0;
    CSRWriteVal = '0; PMPFlushAck = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst:ready", 64'(CSRReady), 64'd1);
    check("rst:respvalid", 64'(CSRRespValid), 64'd0);
    check("rst:illegal", 64'(CSRIllegal), 64'd0);
    check("rst:readval", CSRReadVal, 64'd0);
    check("rst:flushreq", 64'(PMPFlushReq), 64'd0);
    check("rst:cfg0", 64'(cfg_w[0]), 64'd0);
    check("rst:addr0", 64'(addr_w[0]), 64'd0);

    xact("rd_addr0", 1'b0, 12'h3B0, 64'd0, 1'b0, 0, 64'd0, 1'b0);

    xact("wr_addr0", 1'b1, 12'h3B0, 64'h1234, 1'b1, 3, 64'd0, 1'b0);
    check("addr0_new", 64'(addr_w[0]), 64'h1234);
    xact("rdback_addr0", 1'b0, 12'h3B0, 64'd0, 1'b0, 0, 64'h1234, 1'b0);

    xact("wr_addr8", 1'b1, 12'h3B8, 64'h77, 1'b1, 2, 64'd0, 1'b0);

    xact("wr_cfg0_a", 1'b1, 12'h3A0, 64'h0899, 1'b1, 0, 64'd0, 1'b0);
    check("cfg0_a", 64'(cfg_w[0]), 64'h99);
    check("cfg1_a", 64'(cfg_w[1]), 64'h08);
    xact("wr_addr0_locked", 1'b1, 12'h3B0, 64'h5, 1'b0, 0, 64'h1234, 1'b0);
    check("addr0_locked", 64'(addr_w[0]), 64'h1234);

    xact("wr_cfg1_lock", 1'b1, 12'h3A0, 64'h8899, 1'b1, 1, 64'h0899, 1'b0);
    check("cfg1_lock", 64'(cfg_w[1]), 64'h88);
    xact("wr_cfg1_clear", 1'b1, 12'h3A0, 64'h0099, 1'b0, 0, 64'h8899, 1'b0);
    check("cfg1_kept", 64'(cfg_w[1]), 64'h88);

    xact("wr_cfg2_rsvd", 1'b1, 12'h3A0, 64'h02_8899, 1'b0, 0, 64'h8899, 1'b0);
    check("cfg2_rsvd", 64'(cfg_w[2]), 64'h00);
    xact("wr_cfg2_mask", 1'b1, 12'h3A0, 64'hE3_8899, 1'b1, 0, 64'h8899, 1'b0);
    check("cfg2_mask", 64'(cfg_w[2]), 64'h83);
    xact("rd_cfg0", 1'b0, 12'h3A0, 64'd0, 1'b0, 0, 64'h83_8899, 1'b0);

    xact("wr_cfg2idx", 1'b1, 12'h3A2, 64'h9800_8800, 1'b1, 1, 64'd0, 1'b0);
    check("cfg9", 64'(cfg_w[9]), 64'h88);
    check("cfg11", 64'(cfg_w[11]), 64'h98);
    xact("wr_addr8_torlock", 1'b1, 12'h3B8, 64'hAB, 1'b0, 0, 64'h77, 1'b0);
    check("addr8_kept", 64'(addr_w[8]), 64'h77);
    xact("wr_addr10_napot_nolock", 1'b1, 12'h3BA, 64'h55, 1'b1, 0, 64'd0, 1'b0);
    check("addr10_new", 64'(addr_w[10]), 64'h55);

    xact("wr_addr3_wide", 1'b1, 12'h3B3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2, 64'd0, 1'b0);
    check("addr3_trunc", 64'(addr_w[3]), 64'h003F_FFFF_FFFF_FFFF);
    xact("rd_addr3", 1'b0, 12'h3B3, 64'd0, 1'b0, 0, 64'h003F_FFFF_FFFF_FFFF, 1'b0);

    xact("rd_addr16_unimpl", 1'b0, 12'h3C0, 64'd0, 1'b0, 0, 64'd0, 1'b0);
    xact("wr_addr16_unimpl", 1'b1, 12'h3C0, 64'hFF, 1'b0, 0, 64'd0, 1'b0);
    xact("wr_cfg8_unimpl", 1'b1, 12'h3A8, 64'h0101_0101, 1'b0, 0, 64'd0, 1'b0);

    xact("rd_cfg_odd", 1'b0, 12'h3A1, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    xact("wr_cfg_odd", 1'b1, 12'h3A1, 64'h0100_0000, 1'b0, 0, 64'd0, 1'b1);
    check("cfg3_untouched", 64'(cfg_w[3]), 64'h00);
    xact("rd_3f0", 1'b0, 12'h3F0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    xact("rd_39f", 1'b0, 12'h39F, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    xact("rd_after_ill", 1'b0, 12'h3B0, 64'd0, 1'b0, 0, 64'h1234, 1'b0);

    // Reset while the flush request is pending
    @(negedge clk);
    CSRReq = 1'b1; CSRWrite = 1'b1; CSRAdr = 12'h3B4; CSRWriteVal = 64'h9;
    @(posedge clk); #1;
    CSRReq = 1'b0;
    @(posedge clk); #1;
    check("rstflush:req", 64'(PMPFlushReq), 64'd1);
    check("rstflush:addr4_committed", 64'(addr_w[4]), 64'h9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstflush:req_drop", 64'(PMPFlushReq), 64'd0);
    check("rstflush:noresp", 64'(CSRRespValid), 64'd0);
    check("rstflush:ready", 64'(CSRReady), 64'd1);
    check("rstflush:addr4_clr", 64'(addr_w[4]), 64'd0);
    check("rstflush:cfg0_clr", 64'(cfg_w[0]), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rstflush:quiet", 64'(CSRRespValid), 64'd0);
    end
    xact("rd_addr0_postrst", 1'b0, 12'h3B0, 64'd0, 1'b0, 0, 64'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
